// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding and constants for the sequential divider
package seq_divider_pkg;

  localparam int DEF_WIDTH = 32;

  // Divide-by-zero quotient is all ones at any width; replicate this bit.
  localparam logic DIVZERO_QUO_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one restoring shift-and-subtract iteration on a full-adder ripple
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] a;
  logic [WIDTH:0] b;
  logic [WIDTH:0] diff;
  logic           carry;

  assign a = {rem_i, bit_i};
  assign b = ~{1'b0, divisor_i};

  // a + ~b + 1 through full-adder cells; final carry-out set means no borrow.
  always_comb begin
    diff  = '0;
    carry = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      diff[i] = a[i] ^ b[i] ^ carry;
      carry   = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  assign qbit_o = carry;
  assign rem_o  = carry ? diff[WIDTH-1:0] : a[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed/unsigned restoring divider with start/busy/done handshake
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             sgn_q, sgn_d;
  logic             dneg_q, dneg_d;
  logic             vneg_q, vneg_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             divzero_q, divzero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] min_neg;

  assign min_neg = {1'b1, {(WIDTH-1){1'b0}}};

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[WIDTH-1]),
    .divisor_i (dmag_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    sgn_d       = sgn_q;
    dneg_d      = dneg_q;
    vneg_d      = vneg_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divzero_d   = divzero_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = {WIDTH{DIVZERO_QUO_BIT}};
            remainder_d = dividend;
            divzero_d   = 1'b1;
            overflow_d  = 1'b0;
            state_d     = ST_DONE;
          end else begin
            sgn_d      = is_signed;
            dneg_d     = is_signed & dividend[WIDTH-1];
            vneg_d     = is_signed & divisor[WIDTH-1];
            quo_d      = dneg_d ? -dividend : dividend;
            dmag_d     = vneg_d ? -divisor : divisor;
            rem_d      = '0;
            cnt_d      = '0;
            divzero_d  = 1'b0;
            overflow_d = 1'b0;
            ovf_pend_d = is_signed && (dividend == min_neg) && (divisor == '1);
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // The quotient register doubles as the dividend shifter.
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        quotient_d  = (sgn_q && (dneg_q ^ vneg_q)) ? -quo_q : quo_q;
        remainder_d = (sgn_q && dneg_q) ? -rem_q : rem_q;
        overflow_d  = ovf_pend_q;
        state_d     = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      sgn_q       <= 1'b0;
      dneg_q      <= 1'b0;
      vneg_q      <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divzero_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dmag_q      <= dmag_d;
      sgn_q       <= sgn_d;
      dneg_q      <= dneg_d;
      vneg_q      <= vneg_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divzero_q   <= divzero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign divzero   = divzero_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        divzero;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_q, prev_r;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .divzero   (divzero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic, truncating division, remainder follows dividend sign.
  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov);
    int sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q  = 32'h8000_0000;
      r  = 32'd0;
      ov = 1'b1;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endtask

  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic restart);
    logic [31:0] eq, er;
    logic        edz, eov;
    int          idx;
    model(sgn, a, b, eq, er, edz, eov);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx   = 0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (done !== 1'b1 && idx < 100) begin
      if (idx == 5) begin
        check("hold_q_in_run", quotient, prev_q);
        check("hold_r_in_run", remainder, prev_r);
      end
      @(negedge clk);
      idx++;
    end
    check("latency", 32'(idx + 1), edz ? 32'd1 : 32'd34);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("divzero", 32'(divzero), 32'(edz));
    check("overflow", 32'(overflow), 32'(eov));
    if (restart) begin
      is_signed = 1'b0;
      dividend  = 32'd77;
      divisor   = 32'd0;
      start     = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("result_held", quotient, eq);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    int pulses;
    logic        rs;
    logic [31:0] ra, rb;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    prev_q    = '0;
    prev_r    = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_flags", {28'd0, busy, done, divzero, overflow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(1'b0, 32'd100, 32'd7, 1'b0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(1'b0, 32'd5, 32'd0, 1'b0);
    do_op(1'b1, 32'd5, 32'd0, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
    do_op(1'b0, 32'd1000, 32'd33, 1'b0);

    // Abandon an operation with an asynchronous reset between edges.
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", 32'(busy), 32'd1);
    check("ignored_start_done", 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_quotient", quotient, 32'd0);
    check("async_rst_remainder", remainder, 32'd0);
    check("async_rst_flags", {28'd0, busy, done, divzero, overflow}, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    prev_q = '0;
    prev_r = '0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("no_done_after_reset", 32'(pulses), 32'd0);
    do_op(1'b0, 32'd9, 32'd3, 1'b0);

    for (int n = 0; n < 30; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom();
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = rs ? 32'hFFFF_FFFF : 32'($urandom_range(1, 3)) << 30;
        4:       rb = -32'($urandom_range(1, 100));
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) ra = 32'($urandom_range(0, 20));
      do_op(rs, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
